io_output_bank: RTL

- Parametrised, memory-mapped bank of N_PORTS output port registers on the CPU I/O bus, clocked by io_clk.
- Each channel supports four store operations selected by address:
  - direct write
  - bit-set
  - bit-clear
  - timed pulse, which forces bits high for PULSE_CYCLES cycles and then auto-releases them.
- Drives board-level outputs (LEDs, segment displays, strobes).
- Successor to the single fixed-address output port register.

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_pulse_timer.sv | 49 ++++
 rtl/io_output_bank.sv | 98 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped output port bank: op encodings,
// default base word and the decoded-store record.
package io_pkg;

  typedef enum logic [1:0] {
    IO_OP_WRITE = 2'd0,
    IO_OP_SET   = 2'd1,
    IO_OP_CLEAR = 2'd2,
    IO_OP_PULSE = 2'd3
  } io_op_e;

  localparam logic [5:0] IO_BASE_WORD = 6'd32;

  typedef struct packed {
    logic       hit;
    logic [3:0] ch;
    io_op_e     op;
  } io_dec_t;

endpackage

// File: rtl/io_pulse_timer.sv
// Per-channel pulse mask with a down-counter: load ORs bits in and restarts
// the window; a load on the expiry edge replaces the mask instead.
module io_pulse_timer #(
  parameter int WIDTH        = 32,
  parameter int PULSE_CYCLES = 16
) (
  input  logic             io_clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] pulse_mask,
  output logic             active
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             expire;

  assign expire = (cnt_q == CW'(1));

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    if (expire)      mask_d = '0;
    if (load) begin
      cnt_d  = CW'(PULSE_CYCLES);
      mask_d = expire ? d : (mask_q | d);
    end
  end

  // NOTE: state updates use <= so all flops sample the pre-edge values together.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign pulse_mask = mask_q;
  assign active     = (cnt_q != '0);

endmodule

// File: rtl/io_output_bank.sv
// Bank of N_PORTS output registers with write/set/clear/pulse stores.
// Optional macro IO_READBACK_EN adds a combinational rd_hit/rd_data readback.
module io_output_bank
  import io_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N_PORTS      = 4,
  parameter int BASE_WORD    = int'(IO_BASE_WORD),
  parameter int PULSE_CYCLES = 16
) (
  input  logic                       io_clk,
  input  logic                       clrn,
  input  logic [31:0]                addr,
  input  logic [31:0]                datain,
  input  logic                       write_io_enable,
`ifdef IO_READBACK_EN
  output logic                       rd_hit,
  output logic [31:0]                rd_data,
`endif
  output logic [N_PORTS*WIDTH-1:0]   out_port
);

  io_dec_t          dec;
  logic [5:0]       word;
  logic [6:0]       w_ext;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] data_q    [N_PORTS];
  logic [WIDTH-1:0] data_d    [N_PORTS];
  logic [WIDTH-1:0] mask      [N_PORTS];
  logic [WIDTH-1:0] chan_out  [N_PORTS];
  logic [N_PORTS-1:0] load;
  logic [N_PORTS-1:0] active_unused;
  logic               addr_unused;

  assign addr_unused = ^{addr[31:8], addr[1:0]};
  assign word        = addr[7:2];
  assign w_ext       = {1'b0, word} - 7'(BASE_WORD);
  assign d           = datain[WIDTH-1:0];

  // Subtracting in 7 bits keeps below-base addresses from aliasing into range.
  always_comb begin
    dec.hit = (word >= 6'(BASE_WORD)) && (w_ext < 7'(4 * N_PORTS));
    dec.ch  = w_ext[5:2];
    dec.op  = io_op_e'(w_ext[1:0]);
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      data_d[i] = data_q[i];
      load[i]   = 1'b0;
      if (dec.hit && write_io_enable && dec.ch == 4'(i)) begin
        unique case (dec.op)
          IO_OP_WRITE: data_d[i] = d;
          IO_OP_SET:   data_d[i] = data_q[i] | d;
          IO_OP_CLEAR: data_d[i] = data_q[i] & ~d;
          IO_OP_PULSE: load[i]   = 1'b1;
          default:     data_d[i] = data_q[i];
        endcase
      end
    end
  end

  // NOTE: data_q is a handful of flops, not a RAM, so it is reset as a whole array.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < N_PORTS; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) data_q[i] <= data_d[i];
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_ch
    io_pulse_timer #(
      .WIDTH        (WIDTH),
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_timer (
      .io_clk     (io_clk),
      .clrn       (clrn),
      .load       (load[g]),
      .d          (d),
      .pulse_mask (mask[g]),
      .active     (active_unused[g])
    );
    assign chan_out[g]                  = data_q[g] | mask[g];
    assign out_port[g*WIDTH +: WIDTH]   = chan_out[g];
  end

`ifdef IO_READBACK_EN
  always_comb begin
    rd_hit  = dec.hit;
    rd_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dec.hit && dec.ch == 4'(i)) rd_data[WIDTH-1:0] = chan_out[i];
    end
  end
`endif

endmodule
